dictionary_cam_loader: RTL and testbench

Parametrised, sequential successor to the field dictionaries used by the code-compression datapath. It holds up to DEPTH uncompressed field values with a valid count, and is filled through a valid/ready load handshake controlled by a small state machine. It serves two independent registered lookup channels every cycle:
- decode: key -> value.
- encode: value -> lowest matching key, with hit flag.

Compressor and decompressor stages attach directly to the two lookup channels.

---
 rtl/dictionary_cam_loader_if.sv | 44 ++++
 rtl/dictionary_cam_loader.sv | 116 +++++++++++
 tb/tb_dictionary_cam_loader.sv | 208 ++++++++++++++++++++
 3 files changed

// File: rtl/dictionary_cam_loader_if.sv
// Load handshake and the two lookup channels of the dictionary CAM loader.
// Purely wiring; no latency of its own.
// Load side is valid/ready; lookup channels have no backpressure.
interface dictionary_cam_loader_if #(
  parameter int KEY_WIDTH = 8,
  parameter int VAL_WIDTH = 15
);
  // load side
  logic                 load_start;
  logic                 load_valid;
  logic [VAL_WIDTH-1:0] load_val;
  logic                 load_ready;
  logic                 load_done;
  logic                 table_ready;
  logic [KEY_WIDTH:0]   count;
  // decode channel
  logic                 dec_valid_in;
  logic [KEY_WIDTH-1:0] dec_key_in;
  logic                 dec_valid_out;
  logic [VAL_WIDTH-1:0] dec_val_out;
  logic                 dec_hit_out;
  // encode channel
  logic                 enc_valid_in;
  logic [VAL_WIDTH-1:0] enc_val_in;
  logic                 enc_valid_out;
  logic [KEY_WIDTH-1:0] enc_key_out;
  logic                 enc_hit_out;

  modport slave (
    input  load_start, load_valid, load_val, load_done,
    input  dec_valid_in, dec_key_in, enc_valid_in, enc_val_in,
    output load_ready, table_ready, count,
    output dec_valid_out, dec_val_out, dec_hit_out,
    output enc_valid_out, enc_key_out, enc_hit_out
  );

  modport master (
    output load_start, load_valid, load_val, load_done,
    output dec_valid_in, dec_key_in, enc_valid_in, enc_val_in,
    input  load_ready, table_ready, count,
    input  dec_valid_out, dec_val_out, dec_hit_out,
    input  enc_valid_out, enc_key_out, enc_hit_out
  );
endinterface

// File: rtl/dictionary_cam_loader.sv
// Field dictionary: sequential loader plus key->value decode and value->key encode.
// Lookups: 1 cycle, registered outputs; load write commits on the accepting edge.
// Load stalls via load_ready when not in LOAD or full; lookups never stall.
module dictionary_cam_loader #(
  parameter int KEY_WIDTH = 8,
  parameter int VAL_WIDTH = 15,
  parameter int DEPTH     = 2**KEY_WIDTH
) (
  input  logic                    clk,
  input  logic                    reset,
  dictionary_cam_loader_if.slave  bus
);

  typedef enum logic [1:0] {S_EMPTY, S_LOAD, S_READY} state_t;

  localparam logic [KEY_WIDTH:0] DEPTH_C = (KEY_WIDTH+1)'(DEPTH);

  state_t               state_q, state_d;
  logic [KEY_WIDTH:0]   count_q, count_d;
  logic [VAL_WIDTH-1:0] mem [DEPTH];

  logic                 load_ready;
  logic                 wr_acc;

  logic                 dec_valid_q, dec_hit_q, dec_hit_d;
  logic [VAL_WIDTH-1:0] dec_val_q, dec_val_d;
  logic                 enc_valid_q, enc_hit_q, enc_hit_d;
  logic [KEY_WIDTH-1:0] enc_key_q, enc_key_d;

  // Writes only in LOAD and only while room remains; load_start discards a same-cycle write.
  assign load_ready = (state_q == S_LOAD) && (count_q < DEPTH_C);
  assign wr_acc     = bus.load_valid && load_ready && !bus.load_start;

  // Next state and count: load_start overrides everything, load_done commits after the write.
  always_comb begin
    state_d = state_q;
    count_d = count_q;
    if (bus.load_start) begin
      state_d = S_LOAD;
      count_d = '0;
    end else if (state_q == S_LOAD) begin
      if (wr_acc) count_d = count_q + 1'b1;
      if (bus.load_done || (wr_acc && (count_q + 1'b1 == DEPTH_C))) state_d = S_READY;
    end
  end

  // State and count registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_EMPTY;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
    end
  end

  // Entry storage; never cleared, validity comes from index < count.
  always_ff @(posedge clk) begin
    if (wr_acc) mem[count_q[KEY_WIDTH-1:0]] <= bus.load_val;
  end

  // Decode lookup: hit only in READY with key below count; data zeroed on miss.
  always_comb begin
    dec_hit_d = 1'b0;
    dec_val_d = '0;
    if (bus.dec_valid_in && (state_q == S_READY) && ({1'b0, bus.dec_key_in} < count_q)) begin
      dec_hit_d = 1'b1;
      dec_val_d = mem[bus.dec_key_in];
    end
  end

  // Encode search: scan high to low so the lowest matching index is left standing.
  always_comb begin
    enc_hit_d = 1'b0;
    enc_key_d = '0;
    if (bus.enc_valid_in && (state_q == S_READY)) begin
      for (int i = DEPTH-1; i >= 0; i--) begin
        if (((KEY_WIDTH+1)'(i) < count_q) && (mem[i] == bus.enc_val_in)) begin
          enc_hit_d = 1'b1;
          enc_key_d = KEY_WIDTH'(i);
        end
      end
    end
  end

  // Lookup result registers; reset drops any result in flight.
  always_ff @(posedge clk) begin
    if (reset) begin
      dec_valid_q <= 1'b0;
      dec_hit_q   <= 1'b0;
      dec_val_q   <= '0;
      enc_valid_q <= 1'b0;
      enc_hit_q   <= 1'b0;
      enc_key_q   <= '0;
    end else begin
      dec_valid_q <= bus.dec_valid_in;
      dec_hit_q   <= dec_hit_d;
      dec_val_q   <= dec_val_d;
      enc_valid_q <= bus.enc_valid_in;
      enc_hit_q   <= enc_hit_d;
      enc_key_q   <= enc_key_d;
    end
  end

  assign bus.load_ready    = load_ready;
  assign bus.table_ready   = (state_q == S_READY);
  assign bus.count         = count_q;
  assign bus.dec_valid_out = dec_valid_q;
  assign bus.dec_hit_out   = dec_hit_q;
  assign bus.dec_val_out   = dec_val_q;
  assign bus.enc_valid_out = enc_valid_q;
  assign bus.enc_hit_out   = enc_hit_q;
  assign bus.enc_key_out   = enc_key_q;

endmodule

// File: tb/tb_dictionary_cam_loader.sv
// Directed bench for dictionary_cam_loader: a full-size instance and a DEPTH=4 instance.
// Inputs change 1 ns after the rising edge; outputs are checked at the same point.
// Expected values are hand-computed constants.
module tb_dictionary_cam_loader;

  logic clk = 1'b0;
  logic reset;
  int   n_chk = 0;
  int   n_err = 0;

  always #5 clk = ~clk;

  dictionary_cam_loader_if #(.KEY_WIDTH(8), .VAL_WIDTH(15)) bus ();
  dictionary_cam_loader_if #(.KEY_WIDTH(2), .VAL_WIDTH(15)) bus4 ();

  dictionary_cam_loader #(.KEY_WIDTH(8), .VAL_WIDTH(15), .DEPTH(256)) u_dut (
    .clk(clk), .reset(reset), .bus(bus)
  );

  dictionary_cam_loader #(.KEY_WIDTH(2), .VAL_WIDTH(15), .DEPTH(4)) u_dut4 (
    .clk(clk), .reset(reset), .bus(bus4)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // encode stream: value presented and expected hit/key against table {1A2B,0005,1A2B}
  logic [14:0] enc_vals [8] = '{15'h1A2B, 15'h1234, 15'h0005, 15'h7FFF,
                                15'h1A2B, 15'h0000, 15'h0005, 15'h4000};
  logic        enc_hits [8] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
  logic [7:0]  enc_keys [8] = '{8'd0, 8'd0, 8'd1, 8'd0, 8'd0, 8'd0, 8'd1, 8'd0};

  initial begin
    int accepted;
    reset = 1'b1;
    {bus.load_start, bus.load_valid, bus.load_val, bus.load_done} = '0;
    {bus.dec_valid_in, bus.dec_key_in, bus.enc_valid_in, bus.enc_val_in} = '0;
    {bus4.load_start, bus4.load_valid, bus4.load_val, bus4.load_done} = '0;
    {bus4.dec_valid_in, bus4.dec_key_in, bus4.enc_valid_in, bus4.enc_val_in} = '0;
    tick();
    tick();
    reset = 1'b0;

    // reset state
    chk("rst_count", bus.count, 0);
    chk("rst_table_ready", bus.table_ready, 0);
    chk("rst_load_ready", bus.load_ready, 0);
    chk("rst_dec_valid", bus.dec_valid_out, 0);
    chk("rst_enc_valid", bus.enc_valid_out, 0);

    // lookups in EMPTY: valid pulse, always miss
    bus.dec_valid_in = 1'b1; bus.dec_key_in = 8'd0;
    bus.enc_valid_in = 1'b1; bus.enc_val_in = 15'h0;
    tick();
    bus.dec_valid_in = 1'b0; bus.enc_valid_in = 1'b0;
    chk("empty_dec_valid", bus.dec_valid_out, 1);
    chk("empty_dec_hit", bus.dec_hit_out, 0);
    chk("empty_enc_valid", bus.enc_valid_out, 1);
    chk("empty_enc_hit", bus.enc_hit_out, 0);
    chk("empty_count", bus.count, 0);
    chk("empty_table_ready", bus.table_ready, 0);

    // DEPTH=4 instance: hold load_valid for 6 cycles, exactly 4 accepted
    bus4.load_start = 1'b1;
    tick();
    bus4.load_start = 1'b0;
    accepted = 0;
    for (int i = 0; i < 6; i++) begin
      bus4.load_valid = 1'b1;
      bus4.load_val   = 15'(i + 1);
      if (bus4.load_ready) accepted++;
      tick();
      if (i == 3) begin
        chk("d4_ready_drop", bus4.load_ready, 0);
        chk("d4_auto_ready", bus4.table_ready, 1);
      end
    end
    bus4.load_valid = 1'b0;
    chk("d4_accepted", accepted, 4);
    chk("d4_count", bus4.count, 4);
    bus4.dec_valid_in = 1'b1; bus4.dec_key_in = 2'd3;
    bus4.enc_valid_in = 1'b1; bus4.enc_val_in = 15'd5;
    tick();
    chk("d4_dec3_hit", bus4.dec_hit_out, 1);
    chk("d4_dec3_val", bus4.dec_val_out, 4);
    chk("d4_enc_dropped_hit", bus4.enc_hit_out, 0);
    bus4.dec_key_in = 2'd0; bus4.enc_val_in = 15'd2;
    tick();
    bus4.dec_valid_in = 1'b0; bus4.enc_valid_in = 1'b0;
    chk("d4_dec0_val", bus4.dec_val_out, 1);
    chk("d4_enc2_key", bus4.enc_key_out, 1);
    chk("d4_enc2_hit", bus4.enc_hit_out, 1);

    // load three entries with a duplicate, then load_done
    bus.load_start = 1'b1;
    tick();
    bus.load_start = 1'b0;
    chk("load_ready_in_load", bus.load_ready, 1);
    bus.load_valid = 1'b1;
    bus.load_val = 15'h1A2B; tick();
    bus.load_val = 15'h0005; tick();
    bus.load_val = 15'h1A2B; tick();
    bus.load_valid = 1'b0;
    chk("load_only_no_ready", bus.table_ready, 0);
    bus.load_done = 1'b1;
    tick();
    bus.load_done = 1'b0;
    chk("load3_count", bus.count, 3);
    chk("load3_table_ready", bus.table_ready, 1);

    bus.enc_valid_in = 1'b1; bus.enc_val_in = 15'h1A2B;
    bus.dec_valid_in = 1'b1; bus.dec_key_in = 8'd2;
    tick();
    chk("enc_dup_key", bus.enc_key_out, 0);
    chk("enc_dup_hit", bus.enc_hit_out, 1);
    chk("dec2_val", bus.dec_val_out, 15'h1A2B);
    chk("dec2_hit", bus.dec_hit_out, 1);
    bus.dec_key_in = 8'd3; bus.enc_val_in = 15'h0005;
    tick();
    bus.dec_valid_in = 1'b0;
    chk("dec3_hit", bus.dec_hit_out, 0);
    chk("dec3_val", bus.dec_val_out, 0);
    chk("enc5_key", bus.enc_key_out, 1);

    // back-to-back encodes, one per cycle
    for (int i = 0; i < 8; i++) begin
      bus.enc_valid_in = 1'b1;
      bus.enc_val_in   = enc_vals[i];
      tick();
      chk($sformatf("b2b_valid%0d", i), bus.enc_valid_out, 1);
      chk($sformatf("b2b_hit%0d", i), bus.enc_hit_out, enc_hits[i]);
      chk($sformatf("b2b_key%0d", i), bus.enc_key_out, enc_keys[i]);
    end

    // load_start with a write in READY; same-cycle lookups use the old table
    bus.load_start = 1'b1; bus.load_valid = 1'b1; bus.load_val = 15'h7FFF;
    bus.enc_val_in = 15'h0005;
    bus.dec_valid_in = 1'b1; bus.dec_key_in = 8'd0;
    tick();
    bus.load_start = 1'b0; bus.load_valid = 1'b0; bus.dec_valid_in = 1'b0;
    chk("ls_count", bus.count, 0);
    chk("ls_load_state", bus.load_ready, 1);
    chk("ls_table_ready", bus.table_ready, 0);
    chk("ls_old_enc_hit", bus.enc_hit_out, 1);
    chk("ls_old_enc_key", bus.enc_key_out, 1);
    chk("ls_old_dec_val", bus.dec_val_out, 15'h1A2B);
    bus.enc_val_in = 15'h7FFF;
    tick();
    bus.enc_valid_in = 1'b0;
    chk("ls_enc_valid", bus.enc_valid_out, 1);
    chk("ls_enc_miss", bus.enc_hit_out, 0);
    chk("ls_write_dropped", bus.count, 0);

    // reset mid-load after 2 writes, with a decode in flight
    bus.load_valid = 1'b1;
    bus.load_val = 15'h0011; tick();
    bus.load_val = 15'h0022; tick();
    bus.load_valid = 1'b0;
    chk("mid_count2", bus.count, 2);
    reset = 1'b1;
    bus.dec_valid_in = 1'b1; bus.dec_key_in = 8'd0;
    tick();
    reset = 1'b0;
    chk("mid_rst_count", bus.count, 0);
    chk("mid_rst_load_ready", bus.load_ready, 0);
    chk("mid_rst_table_ready", bus.table_ready, 0);
    chk("mid_rst_dec_cleared", bus.dec_valid_out, 0);
    tick();
    bus.dec_valid_in = 1'b0;
    chk("post_rst_dec_valid", bus.dec_valid_out, 1);
    chk("post_rst_dec_hit", bus.dec_hit_out, 0);

    // load_done outside LOAD is ignored
    bus.load_done = 1'b1;
    tick();
    bus.load_done = 1'b0;
    chk("done_in_empty", bus.table_ready, 0);

    // load_done with nothing written: READY but empty
    bus.load_start = 1'b1; tick();
    bus.load_start = 1'b0; bus.load_done = 1'b1; tick();
    bus.load_done = 1'b0;
    chk("empty_done_ready", bus.table_ready, 1);
    chk("empty_done_count", bus.count, 0);
    bus.dec_valid_in = 1'b1; bus.dec_key_in = 8'd0;
    bus.enc_valid_in = 1'b1; bus.enc_val_in = 15'h0011;
    tick();
    bus.dec_valid_in = 1'b0; bus.enc_valid_in = 1'b0;
    chk("empty_done_dec_hit", bus.dec_hit_out, 0);
    chk("empty_done_enc_hit", bus.enc_hit_out, 0);
    tick();
    chk("idle_dec_valid", bus.dec_valid_out, 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
